// File: rtl/univ_shift_reg_pkg.sv
// rtl/univ_shift_reg_pkg.sv - shared mode codes and FSM state encoding for univ_shift_reg
package univ_shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Only the shift/rotate family can be run as a multi-step burst
  function automatic logic is_burst_op(input logic [2:0] mode);
    return (mode >= MODE_SHL) && (mode <= MODE_ASR);
  endfunction

endpackage

// File: rtl/univ_shift_reg_step.sv
// rtl/univ_shift_reg_step.sv - combinational one-step next-value function (univ_shift_step)
module univ_shift_step
  import univ_shift_reg_pkg::*;
#(
  parameter int P_WIDTH = 8
) (
  input  logic [2:0]         op,
  input  logic [P_WIDTH-1:0] q,
  input  logic [P_WIDTH-1:0] d,
  input  logic               sin_l,
  input  logic               sin_r,
  output logic [P_WIDTH-1:0] q_next,
  output logic               sout_next,
  output logic               sout_upd
);

  // Next register value and departing bit for a single application of op
  always_comb begin
    q_next    = q;
    sout_next = 1'b0;
    sout_upd  = 1'b0;
    case (op)
      MODE_LOAD: q_next = d;
      MODE_SHL: begin
        q_next    = {q[P_WIDTH-2:0], sin_l};
        sout_next = q[P_WIDTH-1];
        sout_upd  = 1'b1;
      end
      MODE_SHR: begin
        q_next    = {sin_r, q[P_WIDTH-1:1]};
        sout_next = q[0];
        sout_upd  = 1'b1;
      end
      MODE_ROL: begin
        q_next    = {q[P_WIDTH-2:0], q[P_WIDTH-1]};
        sout_next = q[P_WIDTH-1];
        sout_upd  = 1'b1;
      end
      MODE_ROR: begin
        q_next    = {q[0], q[P_WIDTH-1:1]};
        sout_next = q[0];
        sout_upd  = 1'b1;
      end
      MODE_ASR: begin
        q_next    = {q[P_WIDTH-1], q[P_WIDTH-1:1]};
        sout_next = q[0];
        sout_upd  = 1'b1;
      end
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with single-step and counted burst modes
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int P_WIDTH = 8,
  parameter int P_CNT_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic [2:0]         i_mode,
  input  logic [P_WIDTH-1:0] i_d,
  input  logic               i_sin_l,
  input  logic               i_sin_r,
  input  logic               i_start,
  input  logic [P_CNT_W-1:0] i_count,
  output logic [P_WIDTH-1:0] o_q,
  output logic               o_sout,
  output logic               o_busy,
  output logic               o_done
);

  state_t             state;
  logic [2:0]         mode_l;
  logic [P_CNT_W-1:0] remaining;
  logic [2:0]         op_sel;
  logic [P_WIDTH-1:0] q_next;
  logic               sout_next;
  logic               sout_upd;
  logic               launch;

  // A burst always executes its latched op; idle cycles follow the live mode input
  always_comb begin
    op_sel = (state == ST_RUN) ? mode_l : i_mode;
    launch = i_start && is_burst_op(i_mode);
  end

  univ_shift_step #(
    .P_WIDTH(P_WIDTH)
  ) u_step (
    .op       (op_sel),
    .q        (o_q),
    .d        (i_d),
    .sin_l    (i_sin_l),
    .sin_r    (i_sin_r),
    .q_next   (q_next),
    .sout_next(sout_next),
    .sout_upd (sout_upd)
  );

  // Register, serial-out and burst control; done is a pulse so it always self-clears
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      mode_l    <= MODE_HOLD;
      remaining <= '0;
      o_q       <= '0;
      o_sout    <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_enable) begin
        case (state)
          ST_IDLE: begin
            if (launch) begin
              if (i_count == '0) begin
                o_done <= 1'b1;
              end else begin
                state     <= ST_RUN;
                o_busy    <= 1'b1;
                mode_l    <= i_mode;
                remaining <= i_count;
              end
            end else begin
              o_q <= q_next;
              if (sout_upd) o_sout <= sout_next;
            end
          end
          ST_RUN: begin
            o_q       <= q_next;
            remaining <= remaining - P_CNT_W'(1);
            if (sout_upd) o_sout <= sout_next;
            if (remaining == P_CNT_W'(1)) begin
              state  <= ST_IDLE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg
module tb_univ_shift_reg;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, enable, start, sin_l, sin_r;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic [CW-1:0] count;
  logic [W-1:0]  q;
  logic          sout, busy, done;

  int checks = 0;
  int errors = 0;
  int mq, msout;

  always #5 clk = ~clk;

  univ_shift_reg #(.P_WIDTH(W), .P_CNT_W(CW)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_enable(enable),
    .i_mode  (mode),
    .i_d     (d),
    .i_sin_l (sin_l),
    .i_sin_r (sin_r),
    .i_start (start),
    .i_count (count),
    .o_q     (q),
    .o_sout  (sout),
    .o_busy  (busy),
    .o_done  (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation on an 8-bit value using plain arithmetic
  function automatic void model_step(input int m, input int dv, input int sl, input int sr);
    case (m)
      1: mq = dv;
      2: begin msout = (mq / 128) % 2; mq = (mq * 2 + sl) % 256; end
      3: begin msout = mq % 2; mq = mq / 2 + sr * 128; end
      4: begin msout = mq / 128; mq = (mq * 2) % 256 + mq / 128; end
      5: begin msout = mq % 2; mq = mq / 2 + (mq % 2) * 128; end
      6: begin msout = mq % 2; mq = mq / 2 + (mq / 128) * 128; end
      default: ;
    endcase
  endfunction

  // Closed-form result of n repetitions of op m with constant serial inputs
  function automatic void model_burst(input int m, input int n, input int sl, input int sr);
    int k, s;
    if (n == 0) return;
    case (m)
      2: begin
        msout = (n <= 8) ? (mq >> (8 - n)) & 1 : sl;
        mq = (n >= 8) ? sl * 255 : ((mq << n) & 255) | (sl != 0 ? (1 << n) - 1 : 0);
      end
      3: begin
        msout = (n <= 8) ? (mq >> (n - 1)) & 1 : sr;
        mq = (n >= 8) ? sr * 255 : (mq >> n) | (sr != 0 ? (255 << (8 - n)) & 255 : 0);
      end
      4: begin
        k = n % 8;
        mq = ((mq << k) | (mq >> (8 - k))) & 255;
        msout = mq & 1;
      end
      5: begin
        k = n % 8;
        mq = ((mq >> k) | (mq << (8 - k))) & 255;
        msout = (mq >> 7) & 1;
      end
      6: begin
        s = (mq >> 7) & 1;
        msout = (n <= 8) ? (mq >> (n - 1)) & 1 : s;
        mq = (n >= 8) ? s * 255 : (mq >> n) | (s != 0 ? (255 << (8 - n)) & 255 : 0);
      end
      default: ;
    endcase
  endfunction

  task automatic run_burst(input logic [7:0] lv, input logic [2:0] m, input logic [3:0] n,
                           input int stall_at, input int stall_len,
                           output int bc, output int dc, output logic [7:0] fq);
    mode = 3'b001; d = lv; enable = 1'b1;
    tick;
    mode = m; count = n; start = 1'b1;
    tick;
    chk("launch_q_unchanged", q, lv);
    start = 1'b0; mode = 3'b000; count = '0; d = 8'h5A;
    bc = 0; dc = 0; fq = q;
    for (int k = 0; k < 20; k++) begin
      if (busy) bc++;
      if (done) begin dc++; fq = q; end
      enable = !(k >= stall_at && k < stall_at + stall_len);
      tick;
    end
    enable = 1'b1;
  endtask

  initial begin
    int bc, dc, m, n, sl, sr, dv, en, st, seen;
    logic [7:0] fq;

    rst = 1'b1; enable = 1'b0; start = 1'b0; mode = 3'b000; d = '0;
    sin_l = 1'b0; sin_r = 1'b0; count = '0;
    tick; tick;
    chk("rst_q", q, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sout", sout, 1'b0);

    rst = 1'b0; enable = 1'b1; mode = 3'b001; d = 8'hFF;
    tick;
    chk("load_ff", q, 8'hFF);
    rst = 1'b1; enable = 1'b0; mode = 3'b001; d = 8'h33;
    tick; tick;
    rst = 1'b0; enable = 1'b1; mode = 3'b000;
    chk("rst2_q", q, 8'h00);
    chk("rst2_busy", busy, 1'b0);
    chk("rst2_done", done, 1'b0);

    mode = 3'b001; d = 8'hA5; tick;
    mode = 3'b010; sin_l = 1'b1; tick;
    chk("shl_q", q, 8'h4B);
    chk("shl_sout", sout, 1'b1);
    mode = 3'b110; tick;
    chk("asr_q", q, 8'h25);
    chk("asr_sout", sout, 1'b1);
    mode = 3'b000; tick;
    chk("hold_q", q, 8'h25);

    mode = 3'b001; d = 8'h81; tick;
    mode = 3'b101; tick;
    chk("ror_q", q, 8'hC0);
    mode = 3'b001; d = 8'h80; tick;
    mode = 3'b110; tick;
    chk("asr1_q", q, 8'hC0);
    tick;
    chk("asr2_q", q, 8'hE0);
    mode = 3'b000;

    run_burst(8'h81, 3'b100, 4'd3, 100, 0, bc, dc, fq);
    chk("burst_busy_cycles", bc, 3);
    chk("burst_done_pulses", dc, 1);
    chk("burst_q", fq, 8'h0C);

    run_burst(8'h81, 3'b100, 4'd3, 1, 2, bc, dc, fq);
    chk("stall_busy_cycles", bc, 5);
    chk("stall_done_pulses", dc, 1);
    chk("stall_q", fq, 8'h0C);

    mode = 3'b001; d = 8'h3C; tick;
    mode = 3'b010; start = 1'b1; count = 4'd0; tick;
    start = 1'b0; mode = 3'b000;
    chk("cnt0_q", q, 8'h3C);
    chk("cnt0_done", done, 1'b1);
    chk("cnt0_busy", busy, 1'b0);
    tick;
    chk("cnt0_done_clear", done, 1'b0);
    chk("cnt0_busy_after", busy, 1'b0);

    run_burst(8'h01, 3'b101, 4'd9, 100, 0, bc, dc, fq);
    chk("cnt9_q", fq, 8'h80);
    chk("cnt9_busy_cycles", bc, 9);
    chk("cnt9_done_pulses", dc, 1);

    mode = 3'b001; d = 8'hF0; tick;
    mode = 3'b010; start = 1'b1; count = 4'd5; tick;
    start = 1'b0; mode = 3'b000; tick;
    rst = 1'b1; tick;
    rst = 1'b0;
    chk("abort_q", q, 8'h00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    dc = 0; bc = 0;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (done) dc++;
      if (busy) bc++;
    end
    chk("abort_no_done", dc, 0);
    chk("abort_no_busy", bc, 0);

    mode = 3'b001; d = 8'h77; tick;
    rst = 1'b1; start = 1'b1; mode = 3'b100; count = 4'd3; tick;
    rst = 1'b0; start = 1'b0; mode = 3'b000;
    chk("rst_start_q", q, 8'h00);
    chk("rst_start_busy", busy, 1'b0);
    tick;
    chk("rst_start_busy2", busy, 1'b0);
    chk("rst_start_done2", done, 1'b0);

    mq = 0; msout = 0;
    for (int it = 0; it < 80; it++) begin
      if ($urandom % 3 == 0) begin
        m = 2 + int'($urandom % 5); n = int'($urandom % 16);
        sl = int'($urandom % 2); sr = int'($urandom % 2);
        mode = 3'(m); count = 4'(n); sin_l = sl[0]; sin_r = sr[0];
        start = 1'b1; enable = 1'b1;
        tick;
        start = 1'b0; mode = 3'($urandom); d = 8'($urandom); count = 4'($urandom);
        model_burst(m, n, sl, sr);
        if (n == 0) begin
          chk("rnd_cnt0_done", done, 1'b1);
        end else begin
          seen = 0;
          for (int c = 0; c < 80 && seen == 0; c++) begin
            enable = ($urandom % 4) != 0;
            tick;
            if (done) seen = 1;
          end
          enable = 1'b1;
          chk("rnd_burst_timeout", seen, 1);
        end
        chk("rnd_burst_q", q, mq);
        chk("rnd_burst_sout", sout, msout);
        chk("rnd_burst_busy", busy, 1'b0);
      end else begin
        m = int'($urandom % 8); dv = int'($urandom % 256);
        sl = int'($urandom % 2); sr = int'($urandom % 2);
        en = ($urandom % 5) != 0;
        st = (m == 0 || m == 1 || m == 7) ? int'($urandom % 2) : 0;
        mode = 3'(m); d = 8'(dv); sin_l = sl[0]; sin_r = sr[0];
        enable = en[0]; start = st[0]; count = 4'($urandom);
        tick;
        if (en != 0) model_step(m, dv, sl, sr);
        chk("rnd_step_q", q, mq);
        chk("rnd_step_sout", sout, msout);
        chk("rnd_step_busy", busy, 1'b0);
        chk("rnd_step_done", done, 1'b0);
      end
    end
    start = 1'b0; enable = 1'b1; mode = 3'b000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
